mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Round-robin arbiter and sequencer that shares one 16x16 unsigned Dadda multiplier core among NREQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester, registers its operands, and drives them through the combinational core. It captures the product and returns it on a single response channel, tagged with the requester index, using valid/ready backpressure. It sits between the client datapaths and the multiplier, and is the only block that instantiates the core.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- IDW, 3: width of the response tag; must satisfy 2^IDW >= NREQ.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  16*NREQ  multiplicand; requester i uses bits [16i+15:16i].
- req_b  in  16*NREQ  multiplier operand; same packing as req_a.
- req_ready  out  NREQ  one-hot grant pulse; operands are taken in this cycle.
- resp_valid  out  1  a product is held on resp_prod.
- resp_ready  in  1  consumer accepts the product.
- resp_prod  out  32  unsigned product A*B.
- resp_id  out  IDW  index of the requester that owns resp_prod.
- busy  out  1  high whenever state != IDLE.
- op_count  out  16  number of completed responses; wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, EXEC, DONE.
- IDLE: if any req_valid bit is set, grant the winner by asserting req_ready[w] for exactly one cycle. In the same cycle, latch a_r = req_a[w], b_r = req_b[w] and id_r = w, then go to EXEC. Otherwise stay in IDLE.
- EXEC: a_r and b_r feed the multiplier core. At the end of this cycle, register the low 32 bits of the core's 33-bit output into resp_prod. Bit 32 is discarded; it is always 0 for unsigned 16x16 operands. Copy id_r to resp_id and go to DONE.
- DONE: resp_valid = 1; resp_prod and resp_id hold stable.
  - If resp_ready = 1 and no request is pending: return to IDLE and increment op_count.
  - If resp_ready = 1 and a request is pending: grant the next winner in the same cycle, latch its operands, go to EXEC, and increment op_count.
  - If resp_ready = 0: stay in DONE; no grants are issued.
- Arbitration is round-robin over req_valid. Priority pointer ptr starts at 0 and the search goes ptr, ptr+1, ..., wrapping modulo NREQ. After granting w, ptr = (w+1) mod NREQ. ptr changes only on a grant.
- At most one req_ready bit is high in any cycle. req_ready is never asserted in EXEC, or in DONE while resp_ready = 0.
- A requester must hold req_valid and its operands stable until it sees req_ready. Dropping req_valid before the grant is allowed; that request is then not served.
- req_valid bits of non-winning requesters are ignored in a grant cycle. They keep their place for the next arbitration.

## Timing
- Reset (rst_n = 0, asynchronous): state = IDLE, ptr = 0, req_ready = 0, resp_valid = 0, resp_prod = 0, resp_id = 0, busy = 0, op_count = 0, and the a_r, b_r, id_r registers = 0.
- Reset mid-operation: the in-flight request is discarded and no response is produced. The requester treats its handshake as already completed.
- Latency: grant in cycle N (IDLE or DONE), EXEC in N+1, resp_valid first high in N+2.
- Peak throughput: one product every 2 cycles, achieved with resp_ready held at 1 and back-to-back requests (grant issued from DONE).
- req_ready is combinational from req_valid, state and ptr. resp_valid, resp_prod, resp_id, busy and op_count are registered.
- The core is purely combinational and must settle within one clk period. That is the critical path: a_r/b_r through the core to resp_prod.
- op_count increments in the cycle where resp_valid & resp_ready; 0xFFFF wraps to 0x0000.

## Test plan
- Single request: requester 2 with a = 0xFFFF, b = 0xFFFF, from IDLE. Expect req_ready = 0b0100 for one cycle, then two cycles later resp_valid = 1, resp_prod = 0xFFFE0001, resp_id = 2. After acceptance op_count = 1 and busy = 0.
- Round-robin fairness: all four req_valid held high, resp_ready = 1, and each requester's operands replaced after its grant. Grant order must be 0, 1, 2, 3, 0, with a new grant every 2 cycles and resp_id following the same order.
- Backpressure: resp_ready = 0 for 5 cycles while requesters 1 and 3 are pending. resp_prod and resp_id must stay stable and no req_ready may pulse. Then raise resp_ready: requester 1 is granted in that same cycle.
- Zero and one operands: 0x0000 * 0x1234 = 0x00000000; 0x0001 * 0xABCD = 0x0000ABCD; 0x8000 * 0x0002 = 0x00010000.
- Reset mid-operation: drop rst_n during EXEC. All outputs must go to zero immediately, with no resp_valid after release. The next grant goes to requester 0 if it is requesting.
- op_count wrap: force 65536 completed transactions (or preload a bench counter). op_count must go 0xFFFF -> 0x0000. Randomised operands are checked against a golden A*B reference model throughout.

Source files
------------

// File: rtl/mul_share_if.sv
// Requester/response bundle between client datapaths and the shared multiplier.
interface mul_share_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][15:0] req_a;
  logic [NREQ-1:0][15:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_prod;
  logic [IDW-1:0]        resp_id;
  logic                  busy;
  logic [15:0]           op_count;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_prod, resp_id, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_prod, resp_id, busy, op_count
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one 16x16 unsigned multiplier core
// among NREQ requesters; tagged product returned on a valid/ready channel.
module mul_share_core (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [32:0] p
);
  // Partial products summed flat; the compression tree is built by synthesis.
  always_comb begin
    p = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p + (33'(a) << i);
  end
endmodule

module mul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input logic      clk,
  input logic      rst_n,
  mul_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr, win, id_r;
  logic [15:0]    a_r, b_r, op_cnt_q;
  logic [32:0]    prod;
  logic           any, grant_en, take;
  logic           unused_msb;

  mul_share_core u_core (.a(a_r), .b(b_r), .p(prod));
  assign unused_msb = prod[32];

  // Scan from ptr upward with wrap; descending loop so the nearest slot wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
        any = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign grant_en      = rst_n && (state == IDLE || (state == DONE && bus.resp_ready));
  assign take          = grant_en && any;
  assign bus.req_ready = take ? (NREQ'(1) << win) : '0;
  assign bus.op_count  = op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      a_r            <= '0;
      b_r            <= '0;
      id_r           <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_prod  <= '0;
      bus.resp_id    <= '0;
      bus.busy       <= 1'b0;
      op_cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_r      <= bus.req_a[win];
            b_r      <= bus.req_b[win];
            id_r     <= win;
            ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            state    <= EXEC;
            bus.busy <= 1'b1;
          end
        end
        EXEC: begin
          bus.resp_prod  <= prod[31:0];
          bus.resp_id    <= id_r;
          bus.resp_valid <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            op_cnt_q       <= op_cnt_q + 16'd1;
            bus.resp_valid <= 1'b0;
            if (take) begin
              a_r   <= bus.req_a[win];
              b_r   <= bus.req_b[win];
              id_r  <= win;
              ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
              state <= EXEC;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: grants, fairness, backpressure, reset, wrap.
module tb_mul_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_share_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int          n_run  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt;
  logic [15:0] ea [NREQ];
  logic [15:0] eb [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  // One isolated transaction from requester i; checks grant, latency, product, tag, count.
  task automatic xact(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string tag);
    int n;
    bus.req_valid[i] = 1'b1;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.resp_ready   = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << i));
    @(posedge clk); #1 bus.req_valid[i] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_prod"}, bus.resp_prod, exp);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'(i));
    @(posedge clk); #1;
    exp_cnt++;
    chk({tag, "_cnt"}, 32'(bus.op_count), 32'(exp_cnt));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pprod;
    logic [15:0] ra, rb;
    int          prev;

    do_reset();
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_prod",  bus.resp_prod, 32'd0);
    chk("rst_id",    32'(bus.resp_id), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_cnt",   32'(bus.op_count), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);

    xact(2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "single");

    // Fairness: all four requesting, fresh operands after each grant.
    do_reset();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ea[i] = 16'h1000 + 16'(i);
      eb[i] = 16'h0003 + 16'(i);
      bus.req_a[i] = ea[i];
      bus.req_b[i] = eb[i];
    end
    bus.req_valid = '1;
    prev  = 0;
    pprod = '0;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % NREQ;
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << w));
      if (k > 0) begin
        chk("rr_valid", 32'(bus.resp_valid), 32'd1);
        chk("rr_id",    32'(bus.resp_id), 32'(prev));
        chk("rr_prod",  bus.resp_prod, pprod);
      end
      pprod = 32'(ea[w]) * 32'(eb[w]);
      prev  = w;
      @(posedge clk); #1;
      ea[w] = ea[w] + 16'h0111;
      eb[w] = eb[w] + 16'h0005;
      bus.req_a[w] = ea[w];
      bus.req_b[w] = eb[w];
      if (k == 4) bus.req_valid = '0;
      @(negedge clk);
      chk("rr_exec_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rr_last_id",   32'(bus.resp_id), 32'd0);
    chk("rr_last_prod", bus.resp_prod, pprod);
    @(posedge clk); #1;
    chk("rr_cnt",  32'(bus.op_count), 32'd5);
    chk("rr_busy", 32'(bus.busy), 32'd0);
    bus.resp_ready = 1'b0;

    // Backpressure with requesters 1 and 3 pending behind a held response.
    do_reset();
    bus.req_valid[0] = 1'b1; bus.req_a[0] = 16'h1234; bus.req_b[0] = 16'h0010;
    @(negedge clk);
    chk("bp_grant0", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_a[1] = 16'h0007; bus.req_b[1] = 16'h0009;
    bus.req_valid[3] = 1'b1; bus.req_a[3] = 16'h00FF; bus.req_b[3] = 16'h0101;
    @(negedge clk);
    chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_prod",  bus.resp_prod, 32'h00012340);
      chk("bp_hold_id",    32'(bus.resp_id), 32'd0);
      @(posedge clk);
    end
    #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    chk("bp_cnt1", 32'(bus.op_count), 32'd1);
    @(negedge clk);
    chk("bp_exec1_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_id1",     32'(bus.resp_id), 32'd1);
    chk("bp_prod1",   bus.resp_prod, 32'h0000003F);
    chk("bp_grant3",  32'(bus.req_ready), 32'h8);
    @(posedge clk); #1 bus.req_valid[3] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_id3",   32'(bus.resp_id), 32'd3);
    chk("bp_prod3", bus.resp_prod, 32'h0000FFFF);
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    exp_cnt = 16'd3;
    chk("bp_cnt3", 32'(bus.op_count), 32'd3);

    // Boundary operands and random vectors against A*B.
    for (int r = 0; r < 6; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      xact(r % NREQ, ra, rb, 32'(ra) * 32'(rb), "rand");
    end
    xact(1, 16'h0000, 16'h1234, 32'h00000000, "zero");
    xact(2, 16'h0001, 16'hABCD, 32'h0000ABCD, "one");
    xact(3, 16'h8000, 16'h0002, 32'h00010000, "msb");

    // Reset during EXEC: outputs clear at once, no stray response, ptr back to 0.
    bus.req_valid[2] = 1'b1; bus.req_a[2] = 16'h0003; bus.req_b[2] = 16'h0005;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("mr_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.resp_valid), 32'd0);
    chk("mr_prod",  bus.resp_prod, 32'd0);
    chk("mr_id",    32'(bus.resp_id), 32'd0);
    chk("mr_busy",  32'(bus.busy), 32'd0);
    chk("mr_cnt",   32'(bus.op_count), 32'd0);
    chk("mr_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = '0;
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b1; bus.req_a[0] = 16'h0100; bus.req_b[0] = 16'h0100;
    bus.req_valid[3] = 1'b1; bus.req_a[3] = 16'h0002; bus.req_b[3] = 16'h0003;
    @(negedge clk);
    chk("mr_grant0", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mr_id0",    32'(bus.resp_id), 32'd0);
    chk("mr_prod0",  bus.resp_prod, 32'h00010000);
    chk("mr_grant3", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #1 bus.req_valid[3] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mr_prod3", bus.resp_prod, 32'h00000006);
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    exp_cnt = 16'd2;
    chk("mr_cnt2", 32'(bus.op_count), 32'd2);

    // Counter wrap: preload near the top, then complete two transactions.
    force dut.op_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.op_cnt_q;
    exp_cnt = 16'hFFFE;
    chk("wrap_preload", 32'(bus.op_count), 32'h0000FFFE);
    xact(1, 16'h00AA, 16'h0055, 32'h00003872, "wrap_a");
    xact(2, 16'h1111, 16'h0010, 32'h00011110, "wrap_b");
    chk("wrap_zero", 32'(bus.op_count), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d", n_run, n_fail);
    $fatal(1);
  end
endmodule
